// File: rtl/stack_unit.sv
// stack_unit: register-based LIFO stack serving push/pop requests from the
// control unit. Each accepted request completes in two cycles: one busy
// cycle in PUSH or POP, then a done/err pulse while the FSM is back in IDLE.
// Optional feature macro: STACK_PEEK_EN adds a peek_req input that reads
// the top of stack through the POP path without decrementing sp.
module stack_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              push_req,
    input  logic              pop_req,
`ifdef STACK_PEEK_EN
    input  logic              peek_req,
`endif
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_out,
    output logic              push_done,
    output logic              pop_done,
    output logic              busy,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   sp,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] SP_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH,
        S_POP
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_wrQ;
    logic [DATA_W-1:0]   r_popOut;
    logic [ADDR_W:0]     r_sp;
    logic                r_pushDone;
    logic                r_popDone;
    logic                r_err;
`ifdef STACK_PEEK_EN
    logic                r_peek;
    logic                w_acceptPeek;
`endif

    logic                w_acceptPush;
    logic                w_acceptPop;
    logic                w_conflict;
    logic                w_full;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_wrIdx;
    logic [ADDR_W-1:0]   w_rdIdx;

    // Storage indices wrap modulo DEPTH; sp itself saturates and never wraps.
    assign w_wrIdx = r_sp[ADDR_W-1:0];
    assign w_rdIdx = r_sp[ADDR_W-1:0] - ADDR_W'(1);
    assign w_full  = (r_sp == SP_FULL);
    assign w_empty = (r_sp == '0);

    // Request decode: a request is only taken in IDLE and only when unambiguous.
    always_comb begin
        w_acceptPush = (r_state == S_IDLE) && push_req && !pop_req;
        w_acceptPop  = (r_state == S_IDLE) && pop_req && !push_req;
        w_conflict   = (r_state == S_IDLE) && push_req && pop_req;
`ifdef STACK_PEEK_EN
        w_acceptPeek = (r_state == S_IDLE) && peek_req && !push_req && !pop_req;
`endif
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE dispatches, PUSH and POP always return to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acceptPush) begin
                    w_nextState = S_PUSH;
                end else if (w_acceptPop) begin
                    w_nextState = S_POP;
`ifdef STACK_PEEK_EN
                end else if (w_acceptPeek) begin
                    w_nextState = S_POP;
`endif
                end
            end
            S_PUSH:  w_nextState = S_IDLE;
            S_POP:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Output decodes of registered state.
    always_comb begin
        busy  = (r_state != S_IDLE);
        full  = w_full;
        empty = w_empty;
    end

    // Datapath: stack pointer, popped word, and the one-cycle done/err pulses.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_sp       <= '0;
            r_popOut   <= '0;
            r_pushDone <= 1'b0;
            r_popDone  <= 1'b0;
            r_err      <= 1'b0;
`ifdef STACK_PEEK_EN
            r_peek     <= 1'b0;
`endif
        end else begin
            r_pushDone <= 1'b0;
            r_popDone  <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acceptPush) begin
                        r_wrQ <= push_data;
                    end
                    if (w_conflict) begin
                        r_err <= 1'b1;
                    end
`ifdef STACK_PEEK_EN
                    r_peek <= w_acceptPeek;
`endif
                end
                S_PUSH: begin
                    r_pushDone <= 1'b1;
                    if (w_full) begin
                        r_err <= 1'b1;
                    end else begin
                        r_sp <= r_sp + (ADDR_W + 1)'(1);
                    end
                end
                S_POP: begin
                    r_popDone <= 1'b1;
                    if (w_empty) begin
                        r_err <= 1'b1;
                    end else begin
                        r_popOut <= r_mem[w_rdIdx];
`ifdef STACK_PEEK_EN
                        if (!r_peek) begin
                            r_sp <= r_sp - (ADDR_W + 1)'(1);
                        end
`else
                        r_sp <= r_sp - (ADDR_W + 1)'(1);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage write; contents survive reset, but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (rst_b && (r_state == S_PUSH) && !w_full) begin
            r_mem[w_wrIdx] <= r_wrQ;
        end
    end

    assign pop_out   = r_popOut;
    assign push_done = r_pushDone;
    assign pop_done  = r_popDone;
    assign sp        = r_sp;
    assign err       = r_err;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed self-checking bench for stack_unit with default
// parameters (DATA_W=16, ADDR_W=6, DEPTH=64). The peek scenario is built
// only when STACK_PEEK_EN is defined.
module tb_stack_unit;

    logic        clk;
    logic        rst_b;
    logic        push_req;
    logic        pop_req;
`ifdef STACK_PEEK_EN
    logic        peek_req;
`endif
    logic [15:0] push_data;
    logic [15:0] pop_out;
    logic        push_done;
    logic        pop_done;
    logic        busy;
    logic        full;
    logic        empty;
    logic [6:0]  sp;
    logic        err;

    int passCount;
    int checkCount;

    logic        obsBusy;
    logic        obsPushDone;
    logic        obsPopDone;
    logic        obsErr;
    logic [6:0]  obsSp;
    logic [15:0] obsPopOut;

    stack_unit #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .push_req  (push_req),
        .pop_req   (pop_req),
`ifdef STACK_PEEK_EN
        .peek_req  (peek_req),
`endif
        .push_data (push_data),
        .pop_out   (pop_out),
        .push_done (push_done),
        .pop_done  (pop_done),
        .busy      (busy),
        .full      (full),
        .empty     (empty),
        .sp        (sp),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one sampling edge, then capture the done cycle.
    // Called #1 after a rising edge while the DUT is in IDLE.
    task automatic doOp(input logic iPush, input logic iPop, input logic [15:0] iData);
        push_req  = iPush;
        pop_req   = iPop;
        push_data = iData;
        @(posedge clk); #1;
        obsBusy  = busy;
        push_req = 1'b0;
        pop_req  = 1'b0;
        @(posedge clk); #1;
        obsPushDone = push_done;
        obsPopDone  = pop_done;
        obsErr      = err;
        obsSp       = sp;
        obsPopOut   = pop_out;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        checkCount++; if (sp !== 7'd0) $display("[TB] FAIL reset_sp: got %0d expected 0", sp); else passCount++;
        checkCount++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", empty); else passCount++;
        checkCount++; if (full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", full); else passCount++;
        checkCount++; if (pop_out !== 16'h0000) $display("[TB] FAIL reset_pop_out: got %h expected 0000", pop_out); else passCount++;
        checkCount++; if ({push_done, pop_done, err, busy} !== 4'b0000) $display("[TB] FAIL reset_pulses: got %b expected 0000", {push_done, pop_done, err, busy}); else passCount++;
    endtask

    task automatic test_lifo();
        doOp(1'b1, 1'b0, 16'h1234);
        checkCount++; if (obsBusy !== 1'b1) $display("[TB] FAIL lifo_busy: got %b expected 1", obsBusy); else passCount++;
        checkCount++; if ({obsPushDone, obsErr, obsSp} !== {1'b1, 1'b0, 7'd1}) $display("[TB] FAIL lifo_push1: done/err/sp got %b/%b/%0d expected 1/0/1", obsPushDone, obsErr, obsSp); else passCount++;
        doOp(1'b1, 1'b0, 16'h5678);
        checkCount++; if ({obsPushDone, obsErr, obsSp} !== {1'b1, 1'b0, 7'd2}) $display("[TB] FAIL lifo_push2: done/err/sp got %b/%b/%0d expected 1/0/2", obsPushDone, obsErr, obsSp); else passCount++;
        doOp(1'b0, 1'b1, 16'h0000);
        checkCount++; if ({obsPopDone, obsPushDone, obsErr, obsSp, obsPopOut} !== {1'b1, 1'b0, 1'b0, 7'd1, 16'h5678}) $display("[TB] FAIL lifo_pop1: done/err/sp/pop_out got %b/%b/%0d/%h expected 1/0/1/5678", obsPopDone, obsErr, obsSp, obsPopOut); else passCount++;
        @(posedge clk); #1;
        checkCount++; if ({pop_done, pop_out} !== {1'b0, 16'h5678}) $display("[TB] FAIL lifo_pulse_fall: done/pop_out got %b/%h expected 0/5678", pop_done, pop_out); else passCount++;
        doOp(1'b0, 1'b1, 16'h0000);
        checkCount++; if ({obsPopDone, obsErr, obsSp, obsPopOut} !== {1'b1, 1'b0, 7'd0, 16'h1234}) $display("[TB] FAIL lifo_pop2: done/err/sp/pop_out got %b/%b/%0d/%h expected 1/0/0/1234", obsPopDone, obsErr, obsSp, obsPopOut); else passCount++;
        doOp(1'b0, 1'b1, 16'h0000);
        checkCount++; if ({obsPopDone, obsErr, obsSp, obsPopOut} !== {1'b1, 1'b1, 7'd0, 16'h1234}) $display("[TB] FAIL pop_empty: done/err/sp/pop_out got %b/%b/%0d/%h expected 1/1/0/1234", obsPopDone, obsErr, obsSp, obsPopOut); else passCount++;
    endtask

    task automatic test_boundaries();
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            doOp(1'b1, 1'b0, 16'(i));
            if (obsPushDone !== 1'b1 || obsErr !== 1'b0 || obsSp !== 7'(i + 1)) bad++;
        end
        checkCount++; if (bad != 0) $display("[TB] FAIL fill_pushes: got %0d bad pushes expected 0", bad); else passCount++;
        checkCount++; if ({full, empty, sp} !== {1'b1, 1'b0, 7'd64}) $display("[TB] FAIL fill_full: full/empty/sp got %b/%b/%0d expected 1/0/64", full, empty, sp); else passCount++;
        doOp(1'b1, 1'b0, 16'hFFFF);
        checkCount++; if ({obsPushDone, obsErr, obsSp} !== {1'b1, 1'b1, 7'd64}) $display("[TB] FAIL push_full: done/err/sp got %b/%b/%0d expected 1/1/64", obsPushDone, obsErr, obsSp); else passCount++;
        doOp(1'b0, 1'b1, 16'h0000);
        checkCount++; if ({obsPopDone, obsErr, obsSp, obsPopOut} !== {1'b1, 1'b0, 7'd63, 16'd63}) $display("[TB] FAIL pop_top: done/err/sp/pop_out got %b/%b/%0d/%h expected 1/0/63/003f", obsPopDone, obsErr, obsSp, obsPopOut); else passCount++;
        bad = 0;
        for (int i = 62; i >= 0; i--) begin
            doOp(1'b0, 1'b1, 16'h0000);
            if (obsPopDone !== 1'b1 || obsErr !== 1'b0 || obsPopOut !== 16'(i) || obsSp !== 7'(i)) bad++;
        end
        checkCount++; if (bad != 0) $display("[TB] FAIL drain_pops: got %0d bad pops expected 0", bad); else passCount++;
        checkCount++; if ({full, empty, sp} !== {1'b0, 1'b1, 7'd0}) $display("[TB] FAIL drain_empty: full/empty/sp got %b/%b/%0d expected 0/1/0", full, empty, sp); else passCount++;
    endtask

    task automatic test_conflict();
        doOp(1'b1, 1'b0, 16'h0042);
        doOp(1'b1, 1'b1, 16'h0BAD);
        checkCount++; if (obsBusy !== 1'b0) $display("[TB] FAIL conflict_busy: got %b expected 0", obsBusy); else passCount++;
        // The conflict err pulse sits in the cycle right after the sampling edge.
        @(posedge clk); #1;
        checkCount++; if ({push_done, pop_done, err, sp} !== {1'b0, 1'b0, 1'b0, 7'd1}) $display("[TB] FAIL conflict_after: pd/qd/err/sp got %b/%b/%b/%0d expected 0/0/0/1", push_done, pop_done, err, sp); else passCount++;
        push_req = 1'b1; pop_req = 1'b1; push_data = 16'h0BAD;
        @(posedge clk); #1;
        push_req = 1'b0; pop_req = 1'b0;
        checkCount++; if ({err, push_done, pop_done, busy, sp} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd1}) $display("[TB] FAIL conflict_err: err/pd/qd/busy/sp got %b/%b/%b/%b/%0d expected 1/0/0/0/1", err, push_done, pop_done, busy, sp); else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        push_req = 1'b1; push_data = 16'h0077;
        @(posedge clk); #1;
        push_data = 16'h0099;
        @(posedge clk); #1;
        push_req = 1'b0;
        checkCount++; if ({push_done, sp} !== {1'b1, 7'd2}) $display("[TB] FAIL busy_push: done/sp got %b/%0d expected 1/2", push_done, sp); else passCount++;
        @(posedge clk); #1;
        checkCount++; if ({push_done, busy, sp} !== {1'b0, 1'b0, 7'd2}) $display("[TB] FAIL busy_once: done/busy/sp got %b/%b/%0d expected 0/0/2", push_done, busy, sp); else passCount++;
        doOp(1'b0, 1'b1, 16'h0000);
        checkCount++; if ({obsSp, obsPopOut} !== {7'd1, 16'h0077}) $display("[TB] FAIL busy_data: sp/pop_out got %0d/%h expected 1/0077", obsSp, obsPopOut); else passCount++;
    endtask

    task automatic test_reset_midop();
        push_req = 1'b1; push_data = 16'h0555;
        @(posedge clk); #1;
        push_req = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        checkCount++; if ({push_done, err, busy, sp, pop_out} !== {1'b0, 1'b0, 1'b0, 7'd0, 16'h0000}) $display("[TB] FAIL reset_midop: pd/err/busy/sp/pop_out got %b/%b/%b/%0d/%h expected 0/0/0/0/0000", push_done, err, busy, sp, pop_out); else passCount++;
        @(posedge clk); #1;
        checkCount++; if ({push_done, sp} !== {1'b0, 7'd0}) $display("[TB] FAIL reset_midop_after: done/sp got %b/%0d expected 0/0", push_done, sp); else passCount++;
    endtask

`ifdef STACK_PEEK_EN
    task automatic test_peek();
        doOp(1'b1, 1'b0, 16'hABCD);
        peek_req = 1'b1;
        @(posedge clk); #1;
        peek_req = 1'b0;
        @(posedge clk); #1;
        checkCount++; if ({pop_done, err, sp, pop_out} !== {1'b1, 1'b0, 7'd1, 16'hABCD}) $display("[TB] FAIL peek: done/err/sp/pop_out got %b/%b/%0d/%h expected 1/0/1/abcd", pop_done, err, sp, pop_out); else passCount++;
    endtask
`endif

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst_b      = 1'b0;
        push_req   = 1'b0;
        pop_req    = 1'b0;
        push_data  = 16'h0000;
`ifdef STACK_PEEK_EN
        peek_req   = 1'b0;
`endif
        $display("[TB] starting stack_unit bench");
        test_reset();
        test_lifo();
        test_boundaries();
        test_conflict();
        test_busy_ignore();
        test_reset_midop();
`ifdef STACK_PEEK_EN
        test_peek();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
